// File: rtl/demux_stream_pkg.sv
// Shared types and helpers for the registered one-to-many stream demultiplexer.
package demux_stream_pkg;

  localparam int unsigned DEMUX_MAX_OUT = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic sel_legal(input logic [31:0] sel, input int unsigned n_out);
    return (sel < n_out);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready output register; a write in the same cycle as a drain
// reloads the slot without a bubble.
module demux_slot
  import demux_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drain;

  assign drain = (state_q == SLOT_FULL) & rd_ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (wr_en_i) begin
      state_d = SLOT_FULL;
      data_d  = wr_data_i;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/demux_stream_reg.sv
// Registered stream demultiplexer: routes each accepted word to channel `sel`.
// Optional DEMUX_STREAM_STATS_EN adds drop_cnt/busy_cnt saturating counters.
module demux_stream_reg
  import demux_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_OUT = 5,
  parameter int unsigned SEL_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   sel_err
`ifdef DEMUX_STREAM_STATS_EN
  ,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            busy_cnt
`endif
);

  localparam int unsigned N_SEL = 1 << SEL_W;

  logic             legal;
  logic             accept;
  logic             sel_err_q;
  logic [N_SEL-1:0] valid_pad;
  logic [N_SEL-1:0] ready_pad;
  logic [N_OUT-1:0] wr_en;

  // Pad to the full select range so an illegal sel never indexes past a channel.
  always_comb begin
    valid_pad              = '0;
    ready_pad              = '0;
    valid_pad[N_OUT-1:0]   = out_valid;
    ready_pad[N_OUT-1:0]   = out_ready;
    legal                  = sel_legal(32'(sel), N_OUT);
    in_ready               = legal ? (~valid_pad[sel] | ready_pad[sel]) : 1'b1;
    accept                 = in_valid & in_ready;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign wr_en[k] = accept & legal & (sel == SEL_W'(k));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en[k]),
      .wr_data_i (in_data),
      .rd_ready_i(out_ready[k]),
      .valid_o   (out_valid[k]),
      .data_o    (out_data[k*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= accept & ~legal;
  end

  assign sel_err = sel_err_q;

`ifdef DEMUX_STREAM_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [15:0] busy_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (accept & ~legal & (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (in_valid & ~in_ready & (busy_cnt_q != '1)) busy_cnt_q <= busy_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign busy_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_demux_stream_reg.sv
// Bench for demux_stream_reg: directed scenarios plus randomized traffic checked
// every cycle against a per-channel occupancy model.
module tb_demux_stream_reg;

  localparam int unsigned W = 32;
  localparam int unsigned N = 5;
  localparam int unsigned S = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [S-1:0]   sel;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [N*W-1:0] out_data;
  logic           sel_err;
`ifdef DEMUX_STREAM_STATS_EN
  logic [15:0]    drop_cnt;
  logic [15:0]    busy_cnt;
`endif

  demux_stream_reg #(
    .WIDTH(W),
    .N_OUT(N),
    .SEL_W(S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sel_err  (sel_err)
`ifdef DEMUX_STREAM_STATS_EN
    ,
    .drop_cnt (drop_cnt),
    .busy_cnt (busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          chk_en = 1'b0;

  // Reference state: each channel either holds one word or nothing.
  bit          m_valid [N];
  logic [W-1:0] m_data [N];
  bit          m_err;
  int unsigned m_drop;
  int unsigned m_busy;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    int unsigned s;
    s = sel;
    if (s >= N) return 1'b1;
    return !m_valid[s] || out_ready[s];
  endfunction

  function automatic logic [W-1:0] ch(input int unsigned k);
    return out_data[k*W +: W];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 1'b0;
        m_data[k]  = '0;
      end
      m_err  = 1'b0;
      m_drop = 0;
      m_busy = 0;
    end else begin
      bit acc;
      int unsigned s;
      s   = sel;
      acc = in_valid && exp_ready();
      if (in_valid && !exp_ready() && m_busy < 16'hFFFF) m_busy++;
      m_err = acc && (s >= N);
      if (m_err && m_drop < 16'hFFFF) m_drop++;
      for (int k = 0; k < N; k++)
        if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
      if (acc && s < N) begin
        m_valid[s] = 1'b1;
        m_data[s]  = in_data;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      logic [N-1:0] ev;
      for (int k = 0; k < N; k++) ev[k] = m_valid[k];
      check("m_in_ready", 64'(in_ready), 64'(exp_ready()));
      check("m_out_valid", 64'(out_valid), 64'(ev));
      check("m_sel_err", 64'(sel_err), 64'(m_err));
      for (int k = 0; k < N; k++)
        if (m_valid[k]) check($sformatf("m_data%0d", k), 64'(ch(k)), 64'(m_data[k]));
`ifdef DEMUX_STREAM_STATS_EN
      check("m_drop_cnt", 64'(drop_cnt), 64'(m_drop));
      check("m_busy_cnt", 64'(busy_cnt), 64'(m_busy));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; sel = '0; out_ready = '0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_data", 64'(out_data == '0), 64'h1);
    check("rst_sel_err", 64'(sel_err), 64'h0);
    reset = 1'b0;

    // single word to channel 2
    in_data = 32'hDEADBEEF; sel = 3'd2; in_valid = 1'b1; out_ready = '1;
    #1 check("single_rdy", 64'(in_ready), 64'h1);
    tick(); in_valid = 1'b0;
    check("single_valid", 64'(out_valid), 64'h04);
    check("single_data", 64'(ch(2)), 64'hDEADBEEF);
    tick();
    check("single_gone", 64'(out_valid), 64'h00);

    // backpressure on channel 1
    out_ready = 5'b11101; in_valid = 1'b1; sel = 3'd1; in_data = 32'h11;
    #1 check("bp_rdy1", 64'(in_ready), 64'h1);
    tick(); in_data = 32'h22;
    check("bp_data11", 64'(ch(1)), 64'h11);
    #1 check("bp_stall", 64'(in_ready), 64'h0);
    tick();
    check("bp_hold", 64'(ch(1)), 64'h11);
    check("bp_hold_v", 64'(out_valid[1]), 64'h1);
    out_ready = '1;
    #1 check("bp_rdy2", 64'(in_ready), 64'h1);
    tick(); in_valid = 1'b0;
    check("bp_data22", 64'(ch(1)), 64'h22);
    tick();
    check("bp_empty", 64'(out_valid), 64'h00);

    // stalled channel 0 does not block channel 3
    out_ready = 5'b11110; in_valid = 1'b1; sel = 3'd0; in_data = 32'h55;
    tick(); sel = 3'd3; in_data = 32'hA5;
    #1 check("ind_rdy", 64'(in_ready), 64'h1);
    tick(); in_valid = 1'b0;
    check("ind_valid", 64'(out_valid), 64'h09);
    check("ind_d0", 64'(ch(0)), 64'h55);
    check("ind_d3", 64'(ch(3)), 64'hA5);
    out_ready = '1;
    tick();

    // drain + write on channel 4 in the same cycle
    out_ready = 5'b01111; in_valid = 1'b1; sel = 3'd4; in_data = 32'h1;
    tick(); out_ready = '1; in_data = 32'h2;
    check("dw_d1", 64'(ch(4)), 64'h1);
    #1 check("dw_rdy", 64'(in_ready), 64'h1);
    tick(); in_valid = 1'b0;
    check("dw_valid", 64'(out_valid[4]), 64'h1);
    check("dw_d2", 64'(ch(4)), 64'h2);
    tick();

    // illegal select
    in_valid = 1'b1; sel = 3'd6; in_data = 32'hFF;
    #1 check("ill_rdy", 64'(in_ready), 64'h1);
    tick(); in_valid = 1'b0;
    check("ill_err", 64'(sel_err), 64'h1);
    check("ill_novalid", 64'(out_valid), 64'h00);
`ifdef DEMUX_STREAM_STATS_EN
    check("ill_drop", 64'(drop_cnt), 64'h1);
`endif
    tick();
    check("ill_err_clr", 64'(sel_err), 64'h0);

    // reset with three channels full
    out_ready = '0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = S'(k); in_data = 32'h100 + W'(k);
      tick();
    end
    in_valid = 1'b0;
    check("mid_full", 64'(out_valid), 64'h07);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("mid_valid", 64'(out_valid), 64'h00);
    check("mid_data", 64'(out_data == '0), 64'h1);
    check("mid_err", 64'(sel_err), 64'h0);
`ifdef DEMUX_STREAM_STATS_EN
    check("mid_drop", 64'(drop_cnt), 64'h0);
    check("mid_busy", 64'(busy_cnt), 64'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = S'($urandom_range(0, 7));
      in_data   = $urandom;
      out_ready = N'($urandom);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
